// File: rtl/fifo_rd_stream.sv
// Read-side streamer for an asynch_fifo: pops words into a 2-entry in-order buffer and
// presents them on a valid/ready stream, counting completed handshakes.
module fifo_rd_stream #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rdclk,
    input  logic                  rstb_rdclk,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  read_en,
    input  logic [FIFO_WIDTH-1:0] read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  pop;
    logic                  push;
    logic [2:0]            level;

    assign out_valid  = (occ_q != StEmpty);
    assign out_data   = head_q;
    assign word_count = count_q;
    assign pop        = out_valid & out_ready;
    assign push       = inflight_q;

    // Occupancy after this cycle's pop, counting the word still in flight from the FIFO.
    assign level   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_en = rstb_rdclk & enable & ~fifo_empty & (level < 3'd2);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            StEmpty: begin
                if (push) begin
                    head_d = read_data;
                    occ_d  = StOne;
                end
            end
            StOne: begin
                case ({push, pop})
                    2'b11: head_d = read_data;
                    2'b10: begin
                        tail_d = read_data;
                        occ_d  = StTwo;
                    end
                    2'b01: occ_d = StEmpty;
                    default: ;
                endcase
            end
            StTwo: begin
                // A push without a pop cannot happen here: read_en is withheld at level 2.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = read_data;
                    end else begin
                        occ_d = StOne;
                    end
                end
            end
            default: occ_d = StEmpty;
        endcase
    end

    always_ff @(posedge rdclk or negedge rstb_rdclk) begin
        if (!rstb_rdclk) begin
            occ_q      <= StEmpty;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= read_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (pop) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream: a queue-based model of the upstream FIFO and the
// expected output stream predicts read_en, out_valid, out_data and word_count every cycle.
module tb_fifo_rd_stream;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          rdclk = 1'b0;
    logic          rstb_rdclk;
    logic          enable;
    logic          fifo_empty;
    logic          read_en;
    logic [W-1:0]  read_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] word_count;

    fifo_rd_stream #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .rdclk      (rdclk),
        .rstb_rdclk (rstb_rdclk),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .read_en    (read_en),
        .read_data  (read_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    always #5 rdclk = ~rdclk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus knobs
    bit rst_drv     = 1'b0;
    bit en          = 1'b0;
    bit rdy         = 1'b0;
    bit force_empty = 1'b0;

    // Reference model state
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pend_data;
    bit           pend_valid = 1'b0;
    int           reads_n = 0;
    int           pops_n  = 0;
    int           last_re = 0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    int           cyc = 0;
    int           phase_reads, phase_pops;
    int           first_re_cyc, first_pop_cyc, last_pop_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic new_phase();
        phase_reads   = 0;
        phase_pops    = 0;
        first_re_cyc  = -1;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    task automatic cycle();
        bit exp_valid;
        bit exp_pop;
        bit exp_re;
        @(negedge rdclk);
        rstb_rdclk = rst_drv;
        enable     = en;
        out_ready  = rdy;
        fifo_empty = force_empty || (src_q.size() == 0);
        read_data  = pend_valid ? pend_data : $urandom;
        #1;
        if (!rst_drv) begin
            chk("rst_read_en", read_en, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_out_data", out_data, 0);
            exp_q.delete();
            reads_n    = 0;
            pops_n     = 0;
            last_re    = 0;
            pend_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            exp_valid = (reads_n - last_re - pops_n) > 0;
            chk("out_valid", out_valid, exp_valid);
            chk("word_count", word_count, pops_n % (1 << CW));
            if (prev_hold) chk("hold_data", out_data, prev_data);
            exp_pop = exp_valid && rdy;
            exp_re  = en && !fifo_empty && ((reads_n - pops_n - int'(exp_pop)) < 2);
            chk("read_en", read_en, exp_re);
            if (exp_pop && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q.pop_front());
                pops_n++;
                phase_pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            prev_hold  = exp_valid && !rdy;
            prev_data  = out_data;
            pend_valid = 1'b0;
            // The source follows the DUT's actual pops so a stray read stays visible downstream.
            if (read_en === 1'b1 && src_q.size() > 0) begin
                pend_data  = src_q.pop_front();
                pend_valid = 1'b1;
                exp_q.push_back(pend_data);
                reads_n++;
                phase_reads++;
                if (first_re_cyc < 0) first_re_cyc = cyc;
            end
            last_re = int'(pend_valid);
        end
        cyc++;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        rdy         = 1'b1;
        en          = 1'b1;
        force_empty = 1'b0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < bound) begin
            cycle();
            n++;
        end
        chk("drain_done", n < bound, 1);
    endtask

    initial begin
        rstb_rdclk = 1'b0;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        read_data  = '0;

        // Reset held with a ready FIFO and enable high
        rst_drv = 1'b0;
        en      = 1'b1;
        rdy     = 1'b1;
        for (int i = 1; i <= 4; i++) src_q.push_back(W'(i));
        repeat (4) cycle();
        src_q.delete();
        rst_drv = 1'b1;

        // Streaming 0x1..0x8
        new_phase();
        for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
        drain(40);
        chk("stream_latency", first_pop_cyc - first_re_cyc, 2);
        chk("stream_back_to_back", last_pop_cyc - first_pop_cyc, 7);
        rdy = 1'b0;
        cycle();
        chk("stream_count", word_count, 8);

        // Backpressure for 10 cycles
        new_phase();
        for (int i = 0; i < 6; i++) src_q.push_back($urandom);
        rdy = 1'b0;
        repeat (10) cycle();
        chk("bp_reads", phase_reads, 2);
        chk("bp_full", out_valid, 1);
        drain(40);
        chk("bp_delivered", phase_pops, 6);

        // fifo_empty toggling every cycle, random ready
        new_phase();
        for (int i = 0; i < 30; i++) src_q.push_back($urandom);
        for (int i = 0; i < 60; i++) begin
            force_empty = (cyc % 2) == 0;
            rdy         = 1'($urandom_range(0, 1));
            cycle();
        end
        drain(100);
        chk("toggle_delivered", phase_pops, 30);

        // Disable one cycle after the first read
        new_phase();
        for (int i = 0; i < 5; i++) src_q.push_back($urandom);
        rdy = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 10 && phase_reads == 0; i++) cycle();
        en = 1'b0;
        repeat (10) cycle();
        chk("dis_reads", phase_reads, 1);
        chk("dis_delivered", phase_pops, 1);
        src_q.delete();

        // Random traffic, then reset mid-operation
        for (int i = 0; i < 150; i++) begin
            if (src_q.size() < 4) src_q.push_back($urandom);
            en          = ($urandom_range(0, 7) != 0);
            rdy         = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst_drv = 1'b0;
        repeat (2) cycle();
        src_q.delete();
        rst_drv = 1'b1;

        // Counter wrap: 17 handshakes on a 4-bit count
        new_phase();
        for (int i = 0; i < 17; i++) src_q.push_back($urandom);
        drain(60);
        rdy = 1'b0;
        cycle();
        chk("wrap_count", word_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 32: data word width, equal to the upstream asynch_fifo FIFO_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of word_count.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port rdclk  input  1  read-domain clock; all logic is rising-edge.
REQ-005 SHALL have port rstb_rdclk  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  permits new FIFO reads when 1.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port read_en  output  1  upstream FIFO pop request.
REQ-009 SHALL have port read_data  input  FIFO_WIDTH  upstream FIFO data, valid the cycle after read_en.
REQ-010 SHALL have port out_valid  output  1  out_data holds a word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port out_data  output  FIFO_WIDTH  head word of the buffer.
REQ-013 SHALL have port word_count  output  CNT_WIDTH  count of completed output handshakes.

Function
REQ-014 SHALL hold a 2-entry in-order buffer; occupancy states are EMPTY (0), ONE (1) and TWO (2).
REQ-015 SHALL hold a 1-bit inflight register, set in the cycle after read_en=1; cleared otherwise.
REQ-016 SHALL define pop = out_valid & out_ready and push = inflight; in each cycle read_data is written to the tail when push=1.
REQ-017 SHALL drive read_en = enable & ~fifo_empty & (occupancy + inflight - pop < 2), combinationally.
REQ-018 SHALL never assert read_en while fifo_empty=1 or while rstb_rdclk=0.
REQ-019 SHALL drive out_valid = (occupancy != 0); out_data is the oldest buffered word, registered.
REQ-020 SHALL move occupancy as follows: push without pop +1; pop without push -1; push with pop unchanged, with the head advanced and the new word at the tail.
REQ-021 SHALL update occupancy on simultaneous push and pop in state ONE so that out_data takes the pushed word and out_valid stays 1.
REQ-022 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one word per cycle when fifo_empty=0, enable=1 and out_ready=1 continuously, after a 2-cycle initial latency from read_en to out_valid.
REQ-024 SHALL increment word_count by 1 on every pop, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-025 SHALL stop issuing reads when enable goes 0, still capture an outstanding inflight word, and still deliver buffered words.
REQ-026 SHALL never overflow: push in state TWO without pop is impossible by REQ-017; the implementation SHALL NOT rely on overwrite.
REQ-027 SHALL ignore out_ready while out_valid=0 (no count, no state change).

Reset
REQ-028 SHALL, while rstb_rdclk=0, force occupancy=EMPTY, inflight=0, out_valid=0, out_data=0, word_count=0 and read_en=0.
REQ-029 SHALL, on reset assertion mid-operation, discard buffered and inflight words; the first read after release starts from EMPTY.
REQ-030 SHALL deassert reset synchronously to rdclk via the codebase's reset synchronizer upstream; this block does not synchronize it.

Verification
REQ-031 Reset: rstb_rdclk=0 with fifo_empty=0, enable=1 -> read_en=0, out_valid=0, word_count=0 throughout.
REQ-032 Streaming: FIFO holds 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles starting 2 cycles after the first read_en; word_count=8.
REQ-033 Backpressure: out_ready=0 for 10 cycles -> exactly 2 read_en pulses, occupancy TWO, out_data stable at the first word; on release the words drain in order with no loss.
REQ-034 Empty: fifo_empty toggles every cycle with random out_ready -> read_en is never 1 while fifo_empty=1, and the output sequence matches the input order.
REQ-035 Disable: enable set to 0 one cycle after read_en -> the inflight word is still delivered and there is no further read_en.
REQ-036 Wrap: CNT_WIDTH=4 with 17 handshakes -> word_count reads 1.
